// File: rtl/pwm_pkg.sv
// Shared constants for the PWM duty-ramp sequencer: register addresses,
// sequencer state encoding, CTRL/STATUS bit offsets and default field widths.
package pwm_pkg;

  localparam int DEF_FRE_W  = 2;
  localparam int DEF_DUTY_W = 3;
  localparam int DEF_TICK_W = 16;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LIMITS = 2'd1;
  localparam logic [1:0] ADDR_STEP   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } rampState_t;

  localparam int CTRL_START  = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_FRE    = 3;
  localparam int CTRL_IRQ_EN = 5;

  localparam int LIM_MIN = 0;
  localparam int LIM_MAX = 4;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERR   = 2;
  localparam int STAT_DUTY  = 3;
  localparam int STAT_STATE = 6;

endpackage

// File: rtl/pwm_step_timer.sv
// Reloadable down-counter producing a one-cycle tick every iInterval cycles
// while enabled; an interval of 0 behaves as 1.
module pwm_step_timer
  import pwm_pkg::*;
#(
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iLoad,
  input  logic              iEnable,
  input  logic [TICK_W-1:0] iInterval,
  output logic              oTick
);

  localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

  logic [TICK_W-1:0] count;
  logic [TICK_W-1:0] reloadVal;

  assign reloadVal = (iInterval == '0) ? ONE : iInterval;

  // <= also covers a stray zero count so the timer can never stall
  assign oTick = iEnable && !iLoad && (count <= ONE);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      count <= '0;
    end else if (iLoad || oTick) begin
      count <= reloadVal;
    end else if (iEnable) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Register-mapped breathing sequencer feeding fre/duty of the PWM counter.
// Define PWM_RAMP_IRQ_EN to enable the completion interrupt and CTRL.irq_en.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int FRE_W  = DEF_FRE_W,
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iChipselect_n,
  input  logic              iWrite_n,
  input  logic              iRead_n,
  input  logic [1:0]        iAddress,
  input  logic [31:0]       iData,
  output logic [31:0]       oData,
  output logic [FRE_W-1:0]  oFre,
  output logic [DUTY_W-1:0] oDuty,
  output logic              oBusy,
  output logic              oIrq
);

  rampState_t        state, stateNext;
  logic [DUTY_W-1:0] duty, dutyNext;
  logic [DUTY_W-1:0] dutyMin, dutyMax;
  logic [FRE_W-1:0]  fre;
  logic [TICK_W-1:0] interval;
  logic              loopEn;
  logic              busy, done, err;
  logic              setDone, setErr, timerLoad, tick;
  logic              wrEn, rdEn, startReq, stopReq;
  logic [31:0]       rdMux;
  logic              unusedData;

  assign wrEn     = !iChipselect_n && !iWrite_n;
  assign rdEn     = !iChipselect_n && iWrite_n && !iRead_n;
  assign startReq = wrEn && (iAddress == ADDR_CTRL) && iData[CTRL_START];
  assign stopReq  = wrEn && (iAddress == ADDR_CTRL) && iData[CTRL_STOP];
  assign unusedData = ^iData;

  assign oFre  = fre;
  assign oDuty = duty;
  assign oBusy = busy;

`ifdef PWM_RAMP_IRQ_EN
  logic irqEn;
  assign oIrq = done & irqEn;
`else
  assign oIrq = 1'b0;
`endif

  pwm_step_timer #(
    .TICK_W (TICK_W)
  ) uStepTimer (
    .iClk      (iClk),
    .iReset_n  (iReset_n),
    .iLoad     (timerLoad),
    .iEnable   (state != IDLE),
    .iInterval (interval),
    .oTick     (tick)
  );

  // Limits are compared before stepping, and with >=/<= so a limit moved
  // past the current duty mid-ramp turns the ramp around instead of wrapping.
  always_comb begin
    stateNext = state;
    dutyNext  = duty;
    setDone   = 1'b0;
    setErr    = 1'b0;
    timerLoad = 1'b0;
    if (stopReq) begin
      stateNext = IDLE;
      dutyNext  = '0;
    end else begin
      case (state)
        IDLE: begin
          dutyNext = '0;
          if (startReq) begin
            if (dutyMin <= dutyMax) begin
              stateNext = UP;
              dutyNext  = dutyMin;
              timerLoad = 1'b1;
            end else begin
              setErr = 1'b1;
            end
          end
        end
        UP: begin
          if (tick) begin
            if (duty >= dutyMax) stateNext = DOWN;
            else                 dutyNext  = duty + 1'b1;
          end
        end
        DOWN: begin
          if (tick) begin
            if (duty <= dutyMin) begin
              if (loopEn) begin
                stateNext = UP;
              end else begin
                stateNext = IDLE;
                dutyNext  = '0;
                setDone   = 1'b1;
              end
            end else begin
              dutyNext = duty - 1'b1;
            end
          end
        end
        default: begin
          stateNext = IDLE;
          dutyNext  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= IDLE;
      duty  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= stateNext;
      duty  <= dutyNext;
      busy  <= (stateNext != IDLE);
    end
  end

  always_comb begin
    rdMux = '0;
    case (iAddress)
      ADDR_CTRL: begin
        rdMux[CTRL_LOOP]        = loopEn;
        rdMux[CTRL_FRE +: FRE_W] = fre;
`ifdef PWM_RAMP_IRQ_EN
        rdMux[CTRL_IRQ_EN]      = irqEn;
`endif
      end
      ADDR_LIMITS: begin
        rdMux[LIM_MIN +: DUTY_W] = dutyMin;
        rdMux[LIM_MAX +: DUTY_W] = dutyMax;
      end
      ADDR_STEP: begin
        rdMux[TICK_W-1:0] = interval;
      end
      ADDR_STATUS: begin
        rdMux[STAT_BUSY]          = busy;
        rdMux[STAT_DONE]          = done;
        rdMux[STAT_ERR]           = err;
        rdMux[STAT_DUTY +: DUTY_W] = duty;
        rdMux[STAT_STATE +: 2]    = state;
      end
      default: ;
    endcase
  end

  // A completion or error event outranks a same-cycle write-1-clear.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      loopEn   <= 1'b0;
      fre      <= '0;
      dutyMin  <= '0;
      dutyMax  <= '0;
      interval <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      oData    <= '0;
`ifdef PWM_RAMP_IRQ_EN
      irqEn    <= 1'b0;
`endif
    end else begin
      if (wrEn) begin
        case (iAddress)
          ADDR_CTRL: begin
            loopEn <= iData[CTRL_LOOP];
            fre    <= iData[CTRL_FRE +: FRE_W];
`ifdef PWM_RAMP_IRQ_EN
            irqEn  <= iData[CTRL_IRQ_EN];
`endif
          end
          ADDR_LIMITS: begin
            dutyMin <= iData[LIM_MIN +: DUTY_W];
            dutyMax <= iData[LIM_MAX +: DUTY_W];
          end
          ADDR_STEP: interval <= iData[TICK_W-1:0];
          default: ;
        endcase
      end
      if (setDone)
        done <= 1'b1;
      else if (wrEn && (iAddress == ADDR_STATUS) && iData[STAT_DONE])
        done <= 1'b0;
      if (setErr)
        err <= 1'b1;
      else if (wrEn && (iAddress == ADDR_STATUS) && iData[STAT_ERR])
        err <= 1'b0;
      if (rdEn)
        oData <= rdMux;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: queue-based ramp model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_pwm_ramp_ctrl;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iChipselect_n = 1'b1;
  logic        iWrite_n = 1'b1;
  logic        iRead_n = 1'b1;
  logic [1:0]  iAddress = 2'd0;
  logic [31:0] iData = 32'd0;
  logic [31:0] oData;
  logic [1:0]  oFre;
  logic [2:0]  oDuty;
  logic        oBusy;
  logic        oIrq;

  int checks = 0;
  int errors = 0;

`ifdef PWM_RAMP_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  pwm_ramp_ctrl dut (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iChipselect_n (iChipselect_n),
    .iWrite_n      (iWrite_n),
    .iRead_n       (iRead_n),
    .iAddress      (iAddress),
    .iData         (iData),
    .oData         (oData),
    .oFre          (oFre),
    .oDuty         (oDuty),
    .oBusy         (oBusy),
    .oIrq          (oIrq)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The ramp is a list of per-cycle (duty, state) entries; front = current cycle.
  typedef struct packed {
    logic [2:0] duty;
    logic [1:0] st;
  } step_t;

  step_t       rampQ[$];
  logic        mLoop, mIrqEn, mDone, mErr;
  logic [1:0]  mFre;
  logic [2:0]  mMin, mMax;
  logic [15:0] mInterval;
  logic [31:0] mData;
  logic        mWr, mRd, mWasIdle, mStart, mStop, mFinish, mSetErr;

  task automatic pushLap();
    int n;
    n = (mInterval == 16'd0) ? 1 : int'(mInterval);
    for (int v = int'(mMin); v <= int'(mMax); v++)
      repeat (n) rampQ.push_back(step_t'{duty: 3'(v), st: 2'd1});
    for (int v = int'(mMax); v >= int'(mMin); v--)
      repeat (n) rampQ.push_back(step_t'{duty: 3'(v), st: 2'd2});
  endtask

  function automatic logic [31:0] regWord(input logic [1:0] a);
    logic [31:0] w;
    w = 32'd0;
    case (a)
      2'd0: begin w[1] = mLoop; w[4:3] = mFre; w[5] = IRQ_ON & mIrqEn; end
      2'd1: begin w[2:0] = mMin; w[6:4] = mMax; end
      2'd2: w[15:0] = mInterval;
      default: begin
        w[0] = (rampQ.size() != 0);
        w[1] = mDone;
        w[2] = mErr;
        w[5:3] = (rampQ.size() != 0) ? rampQ[0].duty : 3'd0;
        w[7:6] = (rampQ.size() != 0) ? rampQ[0].st : 2'd0;
      end
    endcase
    return w;
  endfunction

  always @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rampQ.delete();
      mLoop = 0; mIrqEn = 0; mDone = 0; mErr = 0;
      mFre = 0; mMin = 0; mMax = 0; mInterval = 0; mData = 0;
    end else begin
      mWr = !iChipselect_n && !iWrite_n;
      mRd = !iChipselect_n && iWrite_n && !iRead_n;
      if (mRd) mData = regWord(iAddress);
      mWasIdle = (rampQ.size() == 0);
      mStart = mWr && iAddress == 2'd0 && iData[0];
      mStop  = mWr && iAddress == 2'd0 && iData[2];
      mFinish = 0;
      mSetErr = 0;
      if (mStop) begin
        rampQ.delete();
      end else if (!mWasIdle) begin
        void'(rampQ.pop_front());
        if (rampQ.size() == 0) begin
          if (mLoop) pushLap();
          else mFinish = 1;
        end
      end else if (mStart) begin
        if (mMin <= mMax) pushLap();
        else mSetErr = 1;
      end
      if (mWr) begin
        case (iAddress)
          2'd0: begin mLoop = iData[1]; mFre = iData[4:3]; mIrqEn = iData[5]; end
          2'd1: begin mMin = iData[2:0]; mMax = iData[6:4]; end
          2'd2: mInterval = iData[15:0];
          default: begin
            if (iData[1]) mDone = 0;
            if (iData[2]) mErr = 0;
          end
        endcase
      end
      if (mFinish) mDone = 1;
      if (mSetErr) mErr = 1;
    end
  end

  always @(negedge iClk) begin
    chk("oDuty", 32'(oDuty), (rampQ.size() != 0) ? 32'(rampQ[0].duty) : 32'd0);
    chk("oBusy", 32'(oBusy), 32'(rampQ.size() != 0));
    chk("oFre",  32'(oFre),  32'(mFre));
    chk("oIrq",  32'(oIrq),  32'(IRQ_ON & mDone & mIrqEn));
    chk("oData", oData, mData);
  end

  // ---------------- bus tasks ----------------
  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    iChipselect_n = 0; iWrite_n = 0; iAddress = a; iData = d;
    @(posedge iClk); #1;
    iChipselect_n = 1; iWrite_n = 1;
    $display("wr  addr=%0d data=0x%0h", a, d);
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    iChipselect_n = 0; iRead_n = 0; iAddress = a;
    @(posedge iClk); #1;
    iChipselect_n = 1; iRead_n = 1;
    d = oData;
    $display("rd  addr=%0d data=0x%0h", a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge iClk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int trace[26] = '{1,1,1,1, 2,2,2,2, 3,3,3,3, 3,3,3,3, 2,2,2,2, 1,1,1,1, 0,0};
    int cnt;

    // Reset state
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_duty", 32'(oDuty), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_data", oData, 32'd0);
    iReset_n = 1;
    idle(1);
    busRead(2'd3, rd); chk("status_after_reset", rd, 32'h00);

    // Single ramp min=1 max=3 interval=4, fre=2, irq_en=1
    busWrite(2'd1, 32'h31);
    busWrite(2'd2, 32'd4);
    busWrite(2'd0, 32'h31);
    for (int i = 0; i < 26; i++) begin
      chk($sformatf("ramp_trace[%0d]", i), 32'(oDuty), 32'(trace[i]));
      idle(1);
    end
    chk("ramp_busy_low", 32'(oBusy), 32'd0);
    chk("ramp_irq", 32'(oIrq), 32'(IRQ_ON));
    busRead(2'd3, rd); chk("ramp_status_done", rd, 32'h02);
    busRead(2'd0, rd); chk("ctrl_readback", rd, IRQ_ON ? 32'h30 : 32'h10);
    busWrite(2'd3, 32'h2);
    chk("irq_cleared", 32'(oIrq), 32'd0);
    busRead(2'd3, rd); chk("done_cleared", rd, 32'h00);

    // Reset mid-ramp
    busWrite(2'd0, 32'h31);
    idle(5);
    chk("pre_reset_busy", 32'(oBusy), 32'd1);
    #2 iReset_n = 0;
    #1;
    chk("async_rst_duty", 32'(oDuty), 32'd0);
    chk("async_rst_busy", 32'(oBusy), 32'd0);
    chk("async_rst_fre",  32'(oFre),  32'd0);
    chk("async_rst_data", oData, 32'd0);
    @(posedge iClk); #1;
    iReset_n = 1;
    busRead(2'd3, rd); chk("status_post_reset", rd, 32'h00);
    busRead(2'd0, rd); chk("ctrl_post_reset", rd, 32'h00);

    // Error: min > max
    busWrite(2'd1, 32'h25);
    busWrite(2'd0, 32'h01);
    idle(2);
    busRead(2'd3, rd); chk("err_status", rd, 32'h04);
    busWrite(2'd3, 32'h4);
    busRead(2'd3, rd); chk("err_cleared", rd, 32'h00);

    // Start and stop in one write while idle
    busWrite(2'd1, 32'h31);
    busWrite(2'd0, 32'h05);
    idle(2);
    chk("startstop_busy", 32'(oBusy), 32'd0);
    busRead(2'd3, rd); chk("startstop_status", rd, 32'h00);

    // Stop during DOWN (interval 2: UP 1,1,2,2,3,3 then DOWN 3,3,...)
    busWrite(2'd2, 32'd2);
    busWrite(2'd0, 32'h01);
    idle(7);
    chk("down_duty_pre_stop", 32'(oDuty), 32'd3);
    busWrite(2'd0, 32'h04);
    chk("stop_duty", 32'(oDuty), 32'd0);
    chk("stop_busy", 32'(oBusy), 32'd0);
    busRead(2'd3, rd); chk("stop_status_no_done", rd, 32'h00);

    // Loop 0..7..0, clear loop during second UP
    busWrite(2'd1, 32'h70);
    busWrite(2'd2, 32'd1);
    busWrite(2'd0, 32'h03);
    idle(20);
    busWrite(2'd0, 32'h00);
    cnt = 0;
    while (oBusy && cnt < 100) begin
      @(posedge iClk); #1;
      cnt++;
    end
    chk("loop_finish_cycles", 32'(cnt), 32'd11);
    busRead(2'd3, rd); chk("loop_status_done", rd, 32'h02);
    busWrite(2'd3, 32'h2);

    // Same-cycle write and read: write wins, oData holds
    busRead(2'd1, rd); chk("limits_read", rd, 32'h70);
    iChipselect_n = 0; iWrite_n = 0; iRead_n = 0; iAddress = 2'd1; iData = 32'h31;
    @(posedge iClk); #1;
    iChipselect_n = 1; iWrite_n = 1; iRead_n = 1;
    $display("wr+rd addr=1 data=0x31 oData=0x%0h", oData);
    chk("wr_rd_data_held", oData, 32'h70);
    busRead(2'd1, rd); chk("wr_rd_write_applied", rd, 32'h31);

    // Interval 0 acts as 1: duty advances every cycle
    busWrite(2'd1, 32'h70);
    busWrite(2'd2, 32'd0);
    busWrite(2'd0, 32'h01);
    busRead(2'd3, rd); chk("int0_status_a", rd, 32'h41);
    busRead(2'd3, rd); chk("int0_status_b", rd, 32'h49);
    busWrite(2'd0, 32'h04);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
